inst_fetch: RTL and testbench

- Fetch-side master for the instruction ROM: owns the PC and drives the ROM chip-enable and byte address.
- Captures the returned instruction word into a registered IF/ID output with a valid flag.
- Handles decode stall, ID-resolved branch redirect (MIPS delay slot preserved) and exception flush.
- Sits between the ROM and the decode stage; the ROM is combinational, so the fetch address and its data are valid in the same cycle.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_ifid_reg.sv | 54 +++++
 rtl/inst_fetch.sv | 130 +++++++++++++
 tb/tb_inst_fetch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, FSM state encoding and alignment helper for the instruction fetch block.
// Optional feature macro used by the fetch block: FETCH_ALIGN_CHECK_EN.
package inst_fetch_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic INST_VALID   = 1'b1;
  localparam logic INST_INVALID = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_ERR   = 2'd2
  } if_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ifid_reg.sv
// IF/ID capture register: flush clears it, hold freezes it, otherwise it loads the fetched word.
module inst_fetch_ifid_reg
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = INST_INVALID;
    end else if (!hold_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = INST_VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= INST_INVALID;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc_o    = pc_q;
  assign id_inst_o  = inst_q;
  assign id_valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch-side ROM master: PC, IDLE/FETCH FSM, stall/branch/flush handling and IF/ID capture.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned targets in an ERR state instead of truncating them.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic [31:0]       fetch_count_o,
  output logic              fetch_err_o
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              ifid_hold, ifid_flush;
  logic [ADDR_W-1:0] br_tgt, fl_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign br_tgt = branch_target_i;
  assign fl_tgt = flush_pc_i;
`else
  // Without the check, targets are word-aligned silently on load.
  assign br_tgt = branch_target_i & ~ADDR_W'(3);
  assign fl_tgt = flush_pc_i & ~ADDR_W'(3);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    err_d      = err_q;
    ifid_hold  = 1'b1;
    ifid_flush = 1'b0;
    case (state_q)
      IF_IDLE: state_d = IF_FETCH;
      IF_FETCH: begin
        if (flush_i) begin
          pc_d       = fl_tgt;
          ifid_flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          if (is_misaligned(flush_pc_i[1:0])) begin
            state_d = IF_ERR;
            err_d   = 1'b1;
          end
`endif
        end else if (!stall_i) begin
          ifid_hold = 1'b0;
          count_d   = count_q + 32'd1;
          if (branch_flag_i) begin
            pc_d = br_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            // The delay slot is still captured this cycle before trapping.
            if (is_misaligned(branch_target_i[1:0])) begin
              state_d = IF_ERR;
              err_d   = 1'b1;
            end
`endif
          end else begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
          end
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      IF_ERR: begin
        ifid_flush = 1'b1;
        if (flush_i) begin
          pc_d = fl_tgt;
          if (!is_misaligned(flush_pc_i[1:0])) begin
            state_d = IF_FETCH;
            err_d   = 1'b0;
          end
        end
      end
`endif
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  inst_fetch_ifid_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (ifid_flush),
    .hold_i     (ifid_hold),
    .pc_i       (pc_q),
    .inst_i     (rom_inst_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

  assign rom_ce_o      = (state_q == IF_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o    = pc_q;
  assign fetch_count_o = count_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM word n holds 32'h1000_0000+n; checks at 1 time unit after each rising edge.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, flush_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o, rom_inst_i;
  logic [31:0] id_pc_o, id_inst_o;
  logic        id_valid_o;
  logic [31:0] fetch_count_o;
  logic        fetch_err_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign rom_inst_i = 32'h1000_0000 + (rom_addr_o >> 2);

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o),
    .fetch_count_o   (fetch_count_o),
    .fetch_err_o     (fetch_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ce"},    32'(rom_ce_o), 32'd0);
    chk({tag, ".addr"},  rom_addr_o, 32'h0);
    chk({tag, ".valid"}, 32'(id_valid_o), 32'd0);
    chk({tag, ".pc"},    id_pc_o, 32'h0);
    chk({tag, ".inst"},  id_inst_o, 32'h0);
    chk({tag, ".cnt"},   fetch_count_o, 32'd0);
    chk({tag, ".err"},   32'(fetch_err_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
    branch_target_i = '0; flush_pc_i = '0;
    tick(); tick();
    chk_reset("reset");

    rst = 1'b1;
    #1 chk("rel.c0.ce", 32'(rom_ce_o), 32'd0);
    tick();
    chk("rel.c1.ce", 32'(rom_ce_o), 32'd1);
    chk("rel.c1.addr", rom_addr_o, 32'h0);
    chk("rel.c1.valid", 32'(id_valid_o), 32'd0);
    tick();
    chk("rel.c2.inst", id_inst_o, 32'h1000_0000);
    chk("rel.c2.valid", 32'(id_valid_o), 32'd1);
    chk("rel.c2.pc", id_pc_o, 32'h0);
    chk("rel.c2.addr", rom_addr_o, 32'h4);
    tick();
    chk("seq.addr", rom_addr_o, 32'h8);
    chk("seq.pc", id_pc_o, 32'h4);
    chk("seq.cnt", fetch_count_o, 32'd2);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.addr", rom_addr_o, 32'h8);
      chk("stall.pc", id_pc_o, 32'h4);
      chk("stall.cnt", fetch_count_o, 32'd2);
    end
    stall_i = 1'b0;
    tick();
    chk("resume.pc", id_pc_o, 32'h8);
    chk("resume.addr", rom_addr_o, 32'hC);
    chk("resume.cnt", fetch_count_o, 32'd3);

    branch_flag_i = 1'b1; branch_target_i = 32'h40;
    tick();
    chk("br.slot.pc", id_pc_o, 32'hC);
    chk("br.slot.inst", id_inst_o, 32'h1000_0003);
    chk("br.addr", rom_addr_o, 32'h40);
    chk("br.cnt", fetch_count_o, 32'd4);
    branch_flag_i = 1'b0;
    tick();
    chk("br.tgt.pc", id_pc_o, 32'h40);
    chk("br.tgt.inst", id_inst_o, 32'h1000_0010);
    chk("br.tgt.addr", rom_addr_o, 32'h44);

    stall_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h180;
    tick();
    chk("flush.valid", 32'(id_valid_o), 32'd0);
    chk("flush.pc", id_pc_o, 32'h0);
    chk("flush.inst", id_inst_o, 32'h0);
    chk("flush.addr", rom_addr_o, 32'h180);
    chk("flush.cnt", fetch_count_o, 32'd5);
    stall_i = 1'b0; flush_i = 1'b0;
    tick();
    chk("flush.next.pc", id_pc_o, 32'h180);
    chk("flush.next.inst", id_inst_o, 32'h1000_0060);
    chk("flush.next.cnt", fetch_count_o, 32'd6);

    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    tick();
    chk("wrap.load", rom_addr_o, 32'hFFFF_FFFC);
    flush_i = 1'b0;
    tick();
    chk("wrap.addr", rom_addr_o, 32'h0);
    chk("wrap.pc", id_pc_o, 32'hFFFF_FFFC);
    chk("wrap.inst", id_inst_o, 32'h4FFF_FFFF);
    chk("wrap.cnt", fetch_count_o, 32'd7);

    branch_flag_i = 1'b1; branch_target_i = 32'h42;
    tick();
    chk("mis.slot.pc", id_pc_o, 32'h0);
    chk("mis.slot.valid", 32'(id_valid_o), 32'd1);
    chk("mis.cnt", fetch_count_o, 32'd8);
    branch_flag_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis.err", 32'(fetch_err_o), 32'd1);
    chk("mis.ce", 32'(rom_ce_o), 32'd0);
    chk("mis.addr", rom_addr_o, 32'h42);
    tick();
    chk("err.valid", 32'(id_valid_o), 32'd0);
    chk("err.sticky", 32'(fetch_err_o), 32'd1);
    chk("err.cnt", fetch_count_o, 32'd8);
    flush_i = 1'b1; flush_pc_i = 32'h181;
    tick();
    chk("err.misflush.err", 32'(fetch_err_o), 32'd1);
    chk("err.misflush.ce", 32'(rom_ce_o), 32'd0);
    flush_pc_i = 32'h180;
    tick();
    chk("err.clr.err", 32'(fetch_err_o), 32'd0);
    chk("err.clr.ce", 32'(rom_ce_o), 32'd1);
    chk("err.clr.addr", rom_addr_o, 32'h180);
    flush_i = 1'b0;
    tick();
    chk("err.resume.pc", id_pc_o, 32'h180);
    chk("err.resume.valid", 32'(id_valid_o), 32'd1);
    chk("err.resume.cnt", fetch_count_o, 32'd9);
`else
    chk("mis.err", 32'(fetch_err_o), 32'd0);
    chk("mis.ce", 32'(rom_ce_o), 32'd1);
    chk("mis.addr", rom_addr_o, 32'h40);
    tick();
    chk("mis.tgt.pc", id_pc_o, 32'h40);
    chk("mis.tgt.inst", id_inst_o, 32'h1000_0010);
    chk("mis.tgt.cnt", fetch_count_o, 32'd9);
`endif

    stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200; rst = 1'b0;
    tick();
    chk_reset("midrst");
    stall_i = 1'b0; branch_flag_i = 1'b0; rst = 1'b1;
    tick();
    chk("midrst.ce", 32'(rom_ce_o), 32'd1);
    chk("midrst.addr", rom_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
